// File: rtl/jtframe_pal_pkg.sv
// Shared types and constants for the palette colour mixer: fetch FSM states,
// RGB field positions for 4- and 5-bit channel depths, and address width helper.
package jtframe_pal_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRdA,
    StRdB,
    StDone
  } pal_state_e;

  // x RRRRR GGGGG BBBBB
  localparam int unsigned R5_MSB = 14;
  localparam int unsigned R5_LSB = 10;
  localparam int unsigned G5_MSB = 9;
  localparam int unsigned G5_LSB = 5;
  localparam int unsigned B5_MSB = 4;
  localparam int unsigned B5_LSB = 0;

  // xxxx RRRR GGGG BBBB
  localparam int unsigned R4_MSB = 11;
  localparam int unsigned R4_LSB = 8;
  localparam int unsigned G4_MSB = 7;
  localparam int unsigned G4_LSB = 4;
  localparam int unsigned B4_MSB = 3;
  localparam int unsigned B4_LSB = 0;

  // Byte address width: bank bits, colour index, byte-within-entry bit.
  function automatic int unsigned pal_aw(input int unsigned cw, input int unsigned bankw);
    return cw + bankw + 1;
  endfunction

endpackage

// File: rtl/jtframe_dual_ram.sv
// Byte-wide dual-port RAM: port 0 read/write (CPU), port 1 read-only (video).
// Both reads are registered and return the old data on a same-address write.
module jtframe_dual_ram #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 11
) (
  input  logic          clk,
  input  logic          we0_i,
  input  logic [AW-1:0] addr0_i,
  input  logic [DW-1:0] data0_i,
  output logic [DW-1:0] q0_o,
  input  logic [AW-1:0] addr1_i,
  output logic [DW-1:0] q1_o
);

  logic [DW-1:0] mem_q [0:(2**AW)-1];
  logic [DW-1:0] q0_q, q1_q;

  always_ff @(posedge clk) begin
    if (we0_i) mem_q[addr0_i] <= data0_i;
    q0_q <= mem_q[addr0_i];
  end

  always_ff @(posedge clk) begin
    q1_q <= mem_q[addr1_i];
  end

  assign q0_o = q0_q;
  assign q1_o = q1_q;

endmodule

// File: rtl/jtframe_pal_colmix.sv
// Palette colour mixer: per pixel, fetches a two-byte entry from palette RAM and
// drives registered RGB plus blanking, one pixel behind the colour index.
module jtframe_pal_colmix
  import jtframe_pal_pkg::*;
#(
  parameter int unsigned CW          = 9,
  parameter int unsigned BANKW       = 1,
  parameter int unsigned CBITS       = 5,
  parameter bit          HI_FIRST    = 1'b1,
  parameter bit          BLANK_BLACK = 1'b1,
  localparam int unsigned AW         = pal_aw(CW, BANKW),
  localparam int unsigned PBW        = (BANKW > 0) ? BANKW : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pxl_cen_i,
  input  logic             lhbl_i,
  input  logic             lvbl_i,
  input  logic [CW-1:0]    col_addr_i,
  input  logic [PBW-1:0]   pal_bank_i,
  input  logic [AW-1:0]    cpu_addr_i,
  input  logic [7:0]       cpu_dout_i,
  input  logic             cpu_we_i,
  output logic [7:0]       cpu_din_o,
  output logic [CBITS-1:0] red_o,
  output logic [CBITS-1:0] green_o,
  output logic [CBITS-1:0] blue_o,
  output logic             lhbl_dly_o,
  output logic             lvbl_dly_o,
  output logic             fetch_err_o
);

  localparam int unsigned R_MSB = (CBITS == 4) ? R4_MSB : R5_MSB;
  localparam int unsigned R_LSB = (CBITS == 4) ? R4_LSB : R5_LSB;
  localparam int unsigned G_MSB = (CBITS == 4) ? G4_MSB : G5_MSB;
  localparam int unsigned G_LSB = (CBITS == 4) ? G4_LSB : G5_LSB;
  localparam int unsigned B_MSB = (CBITS == 4) ? B4_MSB : B5_MSB;
  localparam int unsigned B_LSB = (CBITS == 4) ? B4_LSB : B5_LSB;

  pal_state_e       state_q, state_d;
  logic [AW-1:0]    base_in, vid_addr;
  logic [AW-2:0]    entry_q;
  logic [7:0]       vid_dout, first_q;
  logic [15:0]      word_q;
  logic             lhbl1_q, lvbl1_q;
  logic             cap_first, cap_word, busy, blank;
  logic [CBITS-1:0] red_q, green_q, blue_q;
  logic             lhbl_dly_q, lvbl_dly_q, fetch_err_q;

  if (BANKW > 0) begin : g_bank
    assign base_in = {pal_bank_i[BANKW-1:0], col_addr_i, 1'b0};
  end else begin : g_nobank
    assign base_in = {col_addr_i, 1'b0};
  end

  // The even byte is read straight from the inputs on the pxl_cen cycle.
  assign vid_addr = pxl_cen_i ? base_in : {entry_q, 1'b1};

  jtframe_dual_ram #(
    .DW(8),
    .AW(AW)
  ) u_ram (
    .clk    (clk),
    .we0_i  (cpu_we_i),
    .addr0_i(cpu_addr_i),
    .data0_i(cpu_dout_i),
    .q0_o   (cpu_din_o),
    .addr1_i(vid_addr),
    .q1_o   (vid_dout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  state_d = StIdle;
      StRdA:   state_d = StRdB;
      StRdB:   state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (pxl_cen_i) state_d = StRdA;
  end

  // A pxl_cen during RD_A/RD_B abandons the fetch in flight.
  always_comb begin
    cap_first = 1'b0;
    cap_word  = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      StRdA: begin
        cap_first = !pxl_cen_i;
        busy      = 1'b1;
      end
      StRdB: begin
        cap_word = !pxl_cen_i;
        busy     = 1'b1;
      end
      default: ;
    endcase
  end

  assign blank = BLANK_BLACK && !(lhbl1_q && lvbl1_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_q     <= '0;
      first_q     <= '0;
      word_q      <= '0;
      lhbl1_q     <= 1'b0;
      lvbl1_q     <= 1'b0;
      red_q       <= '0;
      green_q     <= '0;
      blue_q      <= '0;
      lhbl_dly_q  <= 1'b0;
      lvbl_dly_q  <= 1'b0;
      fetch_err_q <= 1'b0;
    end else begin
      if (pxl_cen_i) begin
        entry_q <= base_in[AW-1:1];
        lhbl1_q <= lhbl_i;
        lvbl1_q <= lvbl_i;
        if (busy) begin
          fetch_err_q <= 1'b1;
        end else begin
          red_q      <= blank ? '0 : word_q[R_MSB:R_LSB];
          green_q    <= blank ? '0 : word_q[G_MSB:G_LSB];
          blue_q     <= blank ? '0 : word_q[B_MSB:B_LSB];
          lhbl_dly_q <= lhbl1_q;
          lvbl_dly_q <= lvbl1_q;
        end
      end
      if (cap_first) first_q <= vid_dout;
      if (cap_word)  word_q  <= HI_FIRST ? {first_q, vid_dout} : {vid_dout, first_q};
    end
  end

  assign red_o       = red_q;
  assign green_o     = green_q;
  assign blue_o      = blue_q;
  assign lhbl_dly_o  = lhbl_dly_q;
  assign lvbl_dly_o  = lvbl_dly_q;
  assign fetch_err_o = fetch_err_q;

  logic unused_bits;
  assign unused_bits = ^{word_q, pal_bank_i, base_in[0]};

endmodule

// File: tb/tb_jtframe_pal_colmix.sv
// Bench for the palette mixer: a 5-bit/hi-first and a 4-bit/lo-first instance
// share one bus and are compared every cycle against a pixel-level model.
module tb_jtframe_pal_colmix;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pxl_cen = 1'b0, lhbl = 1'b1, lvbl = 1'b1;
  logic [8:0]  col_addr = '0;
  logic [0:0]  pal_bank = '0;
  logic [10:0] cpu_addr = '0;
  logic [7:0]  cpu_dout = '0;
  logic        cpu_we = 1'b0;

  logic [7:0]  cpu_din5, cpu_din4;
  logic [4:0]  red5, green5, blue5;
  logic [3:0]  red4, green4, blue4;
  logic        lhbl_dly5, lvbl_dly5, err5;
  logic        lhbl_dly4, lvbl_dly4, err4;

  always #5 clk = ~clk;

  jtframe_pal_colmix #(
    .CW(9), .BANKW(1), .CBITS(5), .HI_FIRST(1'b1), .BLANK_BLACK(1'b1)
  ) u_dut5 (
    .clk(clk), .rst_n(rst_n), .pxl_cen_i(pxl_cen), .lhbl_i(lhbl), .lvbl_i(lvbl),
    .col_addr_i(col_addr), .pal_bank_i(pal_bank), .cpu_addr_i(cpu_addr),
    .cpu_dout_i(cpu_dout), .cpu_we_i(cpu_we), .cpu_din_o(cpu_din5),
    .red_o(red5), .green_o(green5), .blue_o(blue5),
    .lhbl_dly_o(lhbl_dly5), .lvbl_dly_o(lvbl_dly5), .fetch_err_o(err5)
  );

  jtframe_pal_colmix #(
    .CW(9), .BANKW(1), .CBITS(4), .HI_FIRST(1'b0), .BLANK_BLACK(1'b1)
  ) u_dut4 (
    .clk(clk), .rst_n(rst_n), .pxl_cen_i(pxl_cen), .lhbl_i(lhbl), .lvbl_i(lvbl),
    .col_addr_i(col_addr), .pal_bank_i(pal_bank), .cpu_addr_i(cpu_addr),
    .cpu_dout_i(cpu_dout), .cpu_we_i(cpu_we), .cpu_din_o(cpu_din4),
    .red_o(red4), .green_o(green4), .blue_o(blue4),
    .lhbl_dly_o(lhbl_dly4), .lvbl_dly_o(lvbl_dly4), .fetch_err_o(err4)
  );

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Pixel-level reference model
  int  mem_m [0:2047];
  bit  known_m [0:2047];
  int  word5_m, word4_m, b0_m, b1_m, base_m, k_m, exp5, exp4;
  bit  fly_m, plh_m, plv_m, dlh_m, dlv_m, err_m;

  function automatic int rgb5_of(input int w);
    return ((w / 1024) % 32) * 1024 + ((w / 32) % 32) * 32 + w % 32;
  endfunction

  function automatic int rgb4_of(input int w);
    return ((w / 256) % 16) * 256 + ((w / 16) % 16) * 16 + w % 16;
  endfunction

  task automatic model_reset();
    exp5 = 0; exp4 = 0; dlh_m = 0; dlv_m = 0; err_m = 0;
    fly_m = 0; k_m = 0; plh_m = 0; plv_m = 0; word5_m = 0; word4_m = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; pxl_cen = 1'b0; cpu_we = 1'b0;
    #3;
    check("rst_rgb5", 32'({red5, green5, blue5}), 32'd0);
    check("rst_rgb4", 32'({red4, green4, blue4}), 32'd0);
    check("rst_dly", 32'({lhbl_dly5, lvbl_dly5, lhbl_dly4, lvbl_dly4}), 32'd0);
    check("rst_err", 32'({err5, err4}), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic step(input bit pxl, input int col, input int bank, input bit lh, input bit lv,
                      input bit we, input int addr, input int d);
    int  din_m;
    bit  din_chk, blk;
    pxl_cen = pxl; col_addr = 9'(col); pal_bank = 1'(bank); lhbl = lh; lvbl = lv;
    cpu_we = we; cpu_addr = 11'(addr); cpu_dout = 8'(d);
    @(posedge clk);
    #1;
    din_m   = mem_m[addr];
    din_chk = known_m[addr];
    if (pxl) begin
      if (fly_m) begin
        err_m = 1'b1;
      end else begin
        blk   = !(plh_m && plv_m);
        exp5  = blk ? 0 : rgb5_of(word5_m);
        exp4  = blk ? 0 : rgb4_of(word4_m);
        dlh_m = plh_m;
        dlv_m = plv_m;
      end
      base_m = bank * 1024 + col * 2;
      b0_m   = mem_m[base_m];
      plh_m  = lh; plv_m = lv; fly_m = 1'b1; k_m = 1;
    end else if (fly_m) begin
      if (k_m == 1) b1_m = mem_m[base_m + 1];
      k_m++;
      if (k_m == 3) begin
        word5_m = b0_m * 256 + b1_m;
        word4_m = b1_m * 256 + b0_m;
        fly_m   = 1'b0;
      end
    end
    if (we) begin
      mem_m[addr]   = d;
      known_m[addr] = 1'b1;
    end
    check("rgb5", 32'({red5, green5, blue5}), 32'(exp5));
    check("rgb4", 32'({red4, green4, blue4}), 32'(exp4));
    check("dly5", 32'({lhbl_dly5, lvbl_dly5}), 32'({dlh_m, dlv_m}));
    check("dly4", 32'({lhbl_dly4, lvbl_dly4}), 32'({dlh_m, dlv_m}));
    check("fetch_err", 32'({err5, err4}), 32'({err_m, err_m}));
    if (din_chk) begin
      check("cpu_din5", 32'(cpu_din5), 32'(din_m));
      check("cpu_din4", 32'(cpu_din4), 32'(din_m));
    end
  endtask

  task automatic wr(input int addr, input int d);
    step(1'b0, int'(col_addr), int'(pal_bank), lhbl, lvbl, 1'b1, addr, d);
  endtask

  task automatic pixel(input int col, input int bank, input bit lh, input bit lv, input int gap);
    step(1'b1, col, bank, lh, lv, 1'b0, int'($urandom_range(0, 2047)), 0);
    for (int i = 1; i < gap; i++)
      step(1'b0, col, bank, lh, lv, 1'b0, int'($urandom_range(0, 2047)), 0);
  endtask

  bit lh_seq [0:4];

  initial begin
    for (int a = 0; a < 2048; a++) begin
      mem_m[a] = 0; known_m[a] = 1'b0;
    end
    model_reset();
    do_reset();

    for (int a = 0; a < 2048; a++) wr(a, int'($urandom_range(0, 255)));

    // Directed colours for both depths / byte orders
    wr('h010, 'h7C); wr('h011, 'h1F);
    wr('h00A, 'hA5); wr('h00B, 'h03);
    pixel(8, 0, 1'b1, 1'b1, 4);
    pixel(5, 0, 1'b1, 1'b1, 4);
    check("tp1_rgb5", 32'({red5, green5, blue5}), 32'({5'd31, 5'd0, 5'd31}));
    pixel(5, 0, 1'b1, 1'b1, 4);
    check("tp2_rgb4", 32'({red4, green4, blue4}), 32'h3A5);
    step(1'b0, 5, 0, 1'b1, 1'b1, 1'b0, 'h010, 0);
    check("tp_readback", 32'(cpu_din5), 32'h7C);

    // Banking: same index, different banks
    wr('h006, 'h00); wr('h007, 'h1F);
    wr('h406, 'h7C); wr('h407, 'h00);
    pixel(3, 0, 1'b1, 1'b1, 4);
    pixel(3, 0, 1'b1, 1'b1, 4);
    pixel(3, 1, 1'b1, 1'b1, 4);
    check("bank_old", 32'({red5, green5, blue5}), 32'({5'd0, 5'd0, 5'd31}));
    pixel(3, 1, 1'b1, 1'b1, 4);
    check("bank_new", 32'({red5, green5, blue5}), 32'({5'd31, 5'd0, 5'd0}));

    // Blanking: two blanked pixels appear one pixel later
    lh_seq[0] = 1'b1; lh_seq[1] = 1'b0; lh_seq[2] = 1'b0; lh_seq[3] = 1'b1; lh_seq[4] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      pixel(3, 1, lh_seq[i], 1'b1, 4);
      if (i > 0) check("blank_dly", 32'(lhbl_dly5), 32'(lh_seq[i-1]));
    end
    pixel(3, 1, 1'b1, 1'b1, 4);

    // CPU write to the entry on the very cycle its fetch starts
    step(1'b1, 8, 0, 1'b1, 1'b1, 1'b1, 'h010, 'h00);
    for (int i = 1; i < 4; i++) step(1'b0, 8, 0, 1'b1, 1'b1, 1'b0, 0, 0);
    pixel(8, 0, 1'b1, 1'b1, 4);
    check("rdw_old", 32'({red5, green5, blue5}), 32'({5'd31, 5'd0, 5'd31}));
    pixel(8, 0, 1'b1, 1'b1, 4);
    check("rdw_new", 32'({red5, green5, blue5}), 32'({5'd0, 5'd0, 5'd31}));

    // Overrun: close pxl_cen spacing, sticky flag, cleared by reset
    pixel(3, 1, 1'b1, 1'b1, 2);
    pixel(3, 0, 1'b1, 1'b1, 2);
    pixel(5, 0, 1'b1, 1'b1, 2);
    check("ovr_hold", 32'({red5, green5, blue5}), 32'({5'd0, 5'd0, 5'd31}));
    check("ovr_err", 32'(err5), 32'd1);
    pixel(3, 1, 1'b1, 1'b1, 4);
    pixel(3, 0, 1'b1, 1'b1, 4);
    check("ovr_sticky", 32'(err5), 32'd1);
    step(1'b1, 8, 0, 1'b1, 1'b1, 1'b0, 0, 0);
    step(1'b0, 8, 0, 1'b1, 1'b1, 1'b0, 0, 0);
    do_reset();
    pixel(8, 0, 1'b1, 1'b1, 4);
    pixel(5, 0, 1'b1, 1'b1, 4);

    // Randomised traffic with writes often aimed at the entry being fetched
    for (int p = 0; p < 300; p++) begin
      int col, bank, gap;
      bit lh, lv;
      col  = int'($urandom_range(0, 511));
      bank = int'($urandom_range(0, 1));
      gap  = int'($urandom_range(4, 6));
      lh   = ($urandom_range(0, 3) != 0);
      lv   = ($urandom_range(0, 7) != 0);
      for (int c = 0; c < gap; c++) begin
        int addr, r;
        bit we;
        r    = int'($urandom_range(0, 5));
        we   = (r < 2);
        addr = (r == 0) ? bank * 1024 + col * 2 + int'($urandom_range(0, 1))
                        : int'($urandom_range(0, 2047));
        step(c == 0, col, bank, lh, lv, we, addr, int'($urandom_range(0, 255)));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
